// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial sequencer for an external 1-bit ALU cell.
// Accepts a WIDTH-bit operation on start, feeds operand bits LSB-first to the
// cell, recirculates the cell carry and assembles the result.
// Optional feature macro: SERIAL_ALU_ABORT_EN (adds 'abort' input and shadow
// copies of result/carry_o restored on abort).
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, in_x, in_y, sel,  operation request and operands (captured on accept)
//   carry_i
//   abort                    (macro only) cancel a running operation
//   busy, done               RUN indicator, one-cycle completion pulse
//   result, carry_o          assembled result and final carry
//   cell_x, cell_y,          drives to the external cell
//   cell_carry_i, cell_sel
//   cell_sum, cell_carry_o   returns from the external cell
module serial_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             sel,
  input  logic             carry_i,
`ifdef SERIAL_ALU_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_o,
  output logic             cell_x,
  output logic             cell_y,
  output logic             cell_carry_i,
  output logic             cell_sel,
  input  logic             cell_sum,
  input  logic             cell_carry_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x_sh, y_sh, res_r;
  logic [CNT_W-1:0] cnt;
  logic             carry_r, sel_r, carry_o_r;
  logic             accept, last_bit, abort_hit;

`ifdef SERIAL_ALU_ABORT_EN
  logic [WIDTH-1:0] res_shadow;
  logic             carry_shadow;
  assign abort_hit = (state == RUN) && abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort takes priority over the final RUN edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (abort_hit)     state_nxt = IDLE;
        else if (last_bit) state_nxt = DONE;
      end
      DONE: state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; cell drives come only from registers
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    cell_x       = 1'b0;
    cell_y       = 1'b0;
    cell_carry_i = 1'b0;
    cell_sel     = sel_r;
    result       = res_r;
    carry_o      = carry_o_r;
    if (state == RUN) begin
      busy         = 1'b1;
      cell_x       = x_sh[0];
      cell_y       = y_sh[0];
      cell_carry_i = carry_r;
    end
    if (state == DONE) done = 1'b1;
  end

  // Datapath: operand capture, bit-serial shift, result assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_sh      <= '0;
      y_sh      <= '0;
      res_r     <= '0;
      cnt       <= '0;
      carry_r   <= 1'b0;
      sel_r     <= 1'b0;
      carry_o_r <= 1'b0;
`ifdef SERIAL_ALU_ABORT_EN
      res_shadow   <= '0;
      carry_shadow <= 1'b0;
`endif
    end else if (accept) begin
      x_sh    <= in_x;
      y_sh    <= in_y;
      sel_r   <= sel;
      carry_r <= carry_i;
      cnt     <= '0;
`ifdef SERIAL_ALU_ABORT_EN
      res_shadow   <= res_r;
      carry_shadow <= carry_o_r;
`endif
    end else if (state == RUN) begin
`ifdef SERIAL_ALU_ABORT_EN
      if (abort_hit) begin
        res_r     <= res_shadow;
        carry_o_r <= carry_shadow;
      end else begin
`else
      begin
`endif
        x_sh    <= x_sh >> 1;
        y_sh    <= y_sh >> 1;
        res_r   <= {cell_sum, res_r[WIDTH-1:1]};
        carry_r <= cell_carry_o;
        cnt     <= cnt + CNT_W'(1);
        if (last_bit) carry_o_r <= cell_carry_o;
      end
    end
  end

endmodule
